// File: rtl/decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage: opcodes, format enum, decoded record.
package decode_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {
    TYPE_R    = 3'd0,
    TYPE_I    = 3'd1,
    TYPE_S    = 3'd2,
    TYPE_B    = 3'd3,
    TYPE_U    = 3'd4,
    TYPE_J    = 3'd5,
    TYPE_SYS  = 3'd6,
    TYPE_NONE = 3'd7
  } type_e;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_e;

  // pc/imm are carried at 64 bits so one record serves both XLEN builds
  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    type_e       fmt;
    logic [63:0] imm;
    logic        illegal;
  } decoded_t;

  function automatic decoded_t decodedRst();
    decoded_t d;
    d     = '0;
    d.fmt = TYPE_NONE;
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream handshake bundle of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            iValid, oReady, iFlush, oValid, iReady, oIllegal;
  logic [31:0]     iInstr;
  logic [XLEN-1:0] iPc, oPc, oImm;
  logic [6:0]      oOpcode, oFunct7;
  logic [4:0]      oRd, oRs1, oRs2;
  logic [2:0]      oFunct3, oType;

  modport master (
    output iValid, iInstr, iPc, iFlush, iReady,
    input  oReady, oValid, oPc, oOpcode, oRd, oFunct3, oRs1, oRs2, oFunct7, oType, oImm, oIllegal
  );

  modport slave (
    input  iValid, iInstr, iPc, iFlush, iReady,
    output oReady, oValid, oPc, oOpcode, oRd, oFunct3, oRs1, oRs2, oFunct7, oType, oImm, oIllegal
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational instruction word -> decoded_t (fields, format, 64-bit sext immediate, illegal).
module decode_comb
  import decode_pkg::*;
#(
  parameter bit RVE = 1'b0
) (
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  output decoded_t    dec
);

  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [63:0] immI, immS, immB, immU, immJ;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  assign immI = {{52{instr[31]}}, instr[31:20]};
  assign immS = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign immB = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immU = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign immJ = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  type_e       fmt;
  logic        bad, useRd, useRs1, useRs2;
  logic [63:0] imm;

  always_comb begin
    fmt    = TYPE_NONE;
    bad    = 1'b0;
    useRd  = 1'b0;
    useRs1 = 1'b0;
    useRs2 = 1'b0;
    imm    = '0;
    case (op)
      OP: begin
        fmt = TYPE_R;
        {useRd, useRs1, useRs2} = 3'b111;
        if (f7 != 7'b0000000 && f7 != 7'b0100000) bad = 1'b1;
        if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
      end
      OP_IMM, LOAD, JALR: begin
        fmt = TYPE_I; useRd = 1'b1; useRs1 = 1'b1; imm = immI;
      end
      STORE: begin
        fmt = TYPE_S; useRs1 = 1'b1; useRs2 = 1'b1; imm = immS;
      end
      BRANCH: begin
        fmt = TYPE_B; useRs1 = 1'b1; useRs2 = 1'b1; imm = immB;
        if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
      end
      LUI, AUIPC: begin
        fmt = TYPE_U; useRd = 1'b1; imm = immU;
      end
      JAL: begin
        fmt = TYPE_J; useRd = 1'b1; imm = immJ;
      end
      SYSTEM, MISC_MEM: begin
        fmt = TYPE_SYS; useRd = 1'b1; useRs1 = 1'b1; imm = immI;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
    // RV32E/64E: only x0..x15 exist, so bit 4 of any used index is illegal
    if (RVE && ((useRd && instr[11]) || (useRs1 && instr[19]) || (useRs2 && instr[24]))) bad = 1'b1;

    dec         = decodedRst();
    dec.pc      = pc;
    dec.opcode  = op;
    dec.rd      = instr[11:7];
    dec.funct3  = f3;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.funct7  = f7;
    dec.illegal = bad;
    dec.fmt     = bad ? TYPE_NONE : fmt;
    dec.imm     = bad ? 64'd0 : imm;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (output reg + skid reg).
// Optional DECODE_STAGE_PERF_EN adds oDecodeCnt, a count of output transfers.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RVE  = 1'b0
) (
  input  logic          iClk,
  input  logic          iRst,
  decode_stage_if.slave bus
`ifdef DECODE_STAGE_PERF_EN
  ,
  output logic [31:0]   oDecodeCnt
`endif
);

  decoded_t    dec, outReg, skidReg;
  buf_e        state;
  logic        oValidR, oReadyR, accept, drain;
  logic [63:0] pcWide;

  assign pcWide = 64'(bus.iPc);

  decode_comb #(.RVE(RVE)) uDec (
    .instr(bus.iInstr),
    .pc   (pcWide),
    .dec  (dec)
  );

  assign accept = bus.iValid & oReadyR;
  assign drain  = oValidR & bus.iReady;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= EMPTY;
      oValidR <= 1'b0;
      oReadyR <= 1'b1;
      outReg  <= decodedRst();
      skidReg <= decodedRst();
    end else if (bus.iFlush) begin
      // data regs keep stale contents; only occupancy is cleared
      state   <= EMPTY;
      oValidR <= 1'b0;
      oReadyR <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          outReg  <= dec;
          state   <= ONE;
          oValidR <= 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            outReg <= dec;
          end else if (accept) begin
            skidReg <= dec;
            state   <= TWO;
            oReadyR <= 1'b0;
          end else if (drain) begin
            state   <= EMPTY;
            oValidR <= 1'b0;
          end
        end
        TWO: if (drain) begin
          outReg  <= skidReg;
          state   <= ONE;
          oReadyR <= 1'b1;
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef DECODE_STAGE_PERF_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                      oDecodeCnt <= '0;
    else if (oValidR && bus.iReady) oDecodeCnt <= oDecodeCnt + 32'd1;
  end
`endif

  assign bus.oValid   = oValidR;
  assign bus.oReady   = oReadyR;
  assign bus.oPc      = outReg.pc[XLEN-1:0];
  assign bus.oOpcode  = outReg.opcode;
  assign bus.oRd      = outReg.rd;
  assign bus.oFunct3  = outReg.funct3;
  assign bus.oRs1     = outReg.rs1;
  assign bus.oRs2     = outReg.rs2;
  assign bus.oFunct7  = outReg.funct7;
  assign bus.oType    = outReg.fmt;
  assign bus.oImm     = outReg.imm[XLEN-1:0];
  assign bus.oIllegal = outReg.illegal;

  // upper pc/imm bits are dead when XLEN=32
  logic unusedBits;
  assign unusedBits = ^{outReg.pc, outReg.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: one stimulus stream drives an RV32 (RVE=0) and an RV64 (RVE=1) stage in lockstep.
module tb_decode_stage;
  import decode_pkg::*;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iValid = 1'b0, iFlush = 1'b0, iReady = 1'b0;
  logic [31:0] iInstr = '0;
  logic [63:0] iPc = '0;

  always #5 iClk = ~iClk;

  decode_stage_if #(.XLEN(32)) b32 ();
  decode_stage_if #(.XLEN(64)) b64 ();

  assign b32.iValid = iValid; assign b32.iInstr = iInstr; assign b32.iPc = iPc[31:0];
  assign b32.iFlush = iFlush; assign b32.iReady = iReady;
  assign b64.iValid = iValid; assign b64.iInstr = iInstr; assign b64.iPc = iPc;
  assign b64.iFlush = iFlush; assign b64.iReady = iReady;

`ifdef DECODE_STAGE_PERF_EN
  logic [31:0] cnt32, cnt64;
  decode_stage #(.XLEN(32), .RVE(1'b0)) dut32 (.iClk(iClk), .iRst(iRst), .bus(b32), .oDecodeCnt(cnt32));
  decode_stage #(.XLEN(64), .RVE(1'b1)) dut64 (.iClk(iClk), .iRst(iRst), .bus(b64), .oDecodeCnt(cnt64));
`else
  decode_stage #(.XLEN(32), .RVE(1'b0)) dut32 (.iClk(iClk), .iRst(iRst), .bus(b32));
  decode_stage #(.XLEN(64), .RVE(1'b1)) dut64 (.iClk(iClk), .iRst(iRst), .bus(b64));
`endif

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  t32, t64;
    logic [63:0] imm32, imm64;
    logic        ill32, ill64;
  } exp_t;

  exp_t sbq[$];
  exp_t pendItem;
  bit   pushPending = 1'b0;
  bit   popPending  = 1'b0;
  int   nTests = 0, nFail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference decode from the ISA rules, using shifts on a sign-extended word.
  function automatic void refDecode(input logic [31:0] ins, input bit rve,
                                    output logic [2:0] t, output logic [63:0] imm, output logic ill);
    longint s;
    bit bad, uRd, uRs1, uRs2;
    s = longint'($signed(ins));
    bad = 0; uRd = 0; uRs1 = 0; uRs2 = 0; imm = '0; t = 3'd7;
    case (ins[6:0])
      7'h33: begin
        t = 3'd0; uRd = 1; uRs1 = 1; uRs2 = 1;
        bad = !(ins[31:25] inside {7'h00, 7'h20}) ||
              (ins[31:25] == 7'h20 && !(ins[14:12] inside {3'd0, 3'd5}));
      end
      7'h13, 7'h03, 7'h67: begin t = 3'd1; uRd = 1; uRs1 = 1; imm = s >>> 20; end
      7'h23: begin t = 3'd2; uRs1 = 1; uRs2 = 1; imm = ((s >>> 25) << 5) | longint'(ins[11:7]); end
      7'h63: begin
        t = 3'd3; uRs1 = 1; uRs2 = 1; bad = ins[14:12] inside {3'd2, 3'd3};
        imm = ((s >>> 31) << 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      end
      7'h37, 7'h17: begin t = 3'd4; uRd = 1; imm = s & 64'hFFFF_FFFF_FFFF_F000; end
      7'h6F: begin
        t = 3'd5; uRd = 1;
        imm = ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      end
      7'h73, 7'h0F: begin t = 3'd6; uRd = 1; uRs1 = 1; imm = s >>> 20; end
      default: bad = 1;
    endcase
    if (ins[1:0] != 2'b11) bad = 1;
    if (rve && ((uRd && ins[11:7] >= 16) || (uRs1 && ins[19:15] >= 16) || (uRs2 && ins[24:20] >= 16))) bad = 1;
    if (bad) begin t = 3'd7; imm = '0; end
    ill = bad;
  endfunction

  function automatic exp_t mkItem(input logic [31:0] ins, input logic [63:0] pc);
    exp_t e;
    e.instr = ins;
    e.pc    = pc;
    refDecode(ins, 1'b0, e.t32, e.imm32, e.ill32);
    refDecode(ins, 1'b1, e.t64, e.imm64, e.ill64);
    e.imm32 = {32'd0, e.imm32[31:0]};
    return e;
  endfunction

  // One cycle: commit last cycle's accept, drive inputs after the edge, decide this cycle's accept.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic fl, input logic rdy, input logic r);
    @(posedge iClk);
    if (pushPending) sbq.push_back(pendItem);
    pushPending = 1'b0;
    #1;
    iValid = v; iInstr = ins; iPc = pc; iFlush = fl; iReady = rdy;
    if (r && !iRst) begin
      iRst = 1'b1;
      sbq.delete();
      #1;
      chk("asyncRstValid", 64'(b32.oValid), 64'd0);
      chk("asyncRstReady", 64'(b64.oReady), 64'd1);
      chk("asyncRstImm32", 64'(b32.oImm), 64'd0);
      chk("asyncRstImm64", b64.oImm, 64'd0);
    end else begin
      iRst = r;
    end
    @(negedge iClk);
    pushPending = v && !fl && !iRst && (sbq.size() < 2);
    pendItem    = mkItem(ins, pc);
  endtask

  // Monitor: compare presented outputs against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      chk("valid32", 64'(b32.oValid), 64'(sbq.size() > 0));
      chk("valid64", 64'(b64.oValid), 64'(sbq.size() > 0));
      chk("ready32", 64'(b32.oReady), 64'(sbq.size() < 2));
      chk("ready64", 64'(b64.oReady), 64'(sbq.size() < 2));
      if (sbq.size() > 0) begin
        e = sbq[0];
        chk("fields32", 64'({b32.oFunct7, b32.oRs2, b32.oRs1, b32.oFunct3, b32.oRd, b32.oOpcode}), 64'(e.instr));
        chk("fields64", 64'({b64.oFunct7, b64.oRs2, b64.oRs1, b64.oFunct3, b64.oRd, b64.oOpcode}), 64'(e.instr));
        chk("pc32", 64'(b32.oPc), 64'(e.pc[31:0]));
        chk("pc64", b64.oPc, e.pc);
        chk("type32", 64'(b32.oType), 64'(e.t32));
        chk("type64", 64'(b64.oType), 64'(e.t64));
        chk("imm32", 64'(b32.oImm), e.imm32);
        chk("imm64", b64.oImm, e.imm64);
        chk("illegal32", 64'(b32.oIllegal), 64'(e.ill32));
        chk("illegal64", 64'(b64.oIllegal), 64'(e.ill64));
      end
      popPending = (sbq.size() > 0) && iReady && !iFlush && !iRst;
      @(posedge iClk);
      if (!iRst) begin
        if (iFlush)          sbq.delete();
        else if (popPending) void'(sbq.pop_front());
      end
    end
  end

  logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    if (w[6:0] == 7'h33 && $urandom_range(0, 1) == 1) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  function automatic logic [63:0] randPc();
    return {$urandom, $urandom};
  endfunction

  initial begin
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    chk("rstType32", 64'(b32.oType), 64'd7);
    chk("rstType64", 64'(b64.oType), 64'd7);
    chk("rstImm64", b64.oImm, 64'd0);
    chk("rstPc32", 64'(b32.oPc), 64'd0);
    chk("rstFields32", 64'({b32.oFunct7, b32.oRs2, b32.oRs1, b32.oFunct3, b32.oRd, b32.oOpcode, b32.oIllegal}), 64'd0);

    // directed stream at full throughput
    step(1, 32'hFFF00093, 64'h1000, 0, 1, 0);
    step(1, 32'hFE000EE3, 64'h1004, 0, 1, 0);
    step(1, 32'h800000EF, 64'h1008, 0, 1, 0);
    step(1, 32'h40001033, 64'h100C, 0, 1, 0);
    step(1, 32'h00000813, 64'h1010, 0, 1, 0);
    step(1, 32'h40005033, 64'h1014, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 1, 0);

    // backpressure: three offered while iReady is low
    step(1, 32'h00100113, 64'h2000, 0, 0, 0);
    step(1, 32'h00200193, 64'h2004, 0, 0, 0);
    step(1, 32'h00300213, 64'h2008, 0, 0, 0);
    step(1, 32'h00300213, 64'h2008, 0, 0, 0);
    step(1, 32'h00300213, 64'h2008, 0, 1, 0);
    step(1, 32'h00300213, 64'h2008, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0);

    // flush while full with a new instruction offered
    step(1, 32'h00A00513, 64'h3000, 0, 0, 0);
    step(1, 32'h00B00593, 64'h3004, 0, 0, 0);
    step(1, 32'h00C00613, 64'h3008, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1, 0);

    // reset mid-stream
    step(1, 32'h00D00693, 64'h4000, 0, 0, 0);
    step(1, 32'h00E00713, 64'h4004, 0, 0, 0);
    step(1, 32'h00F00793, 64'h4008, 0, 1, 1);
    step(1, 32'h00F00793, 64'h4008, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1, 0);

    // randomized traffic with backpressure and occasional flush
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, randInstr(), randPc(),
           $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, 0);

    repeat (4) step(0, 0, 0, 0, 1, 0);
    @(negedge iClk);
    chk("drainedEmpty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
